// File: rtl/reset_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// reset_seq_pkg: shared state type, default parameters and sizing helper.
// Rev 1.0
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } reset_seq_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_STAGGER     = 4;
    localparam int DEF_NUM_OUT     = 4;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_sequencer_sync.sv
`default_nettype none
// ============================================================================
// rst_sync_chain: async-assert, sync-deassert flop chain with its input tied 1.
// Rev 1.0
// ============================================================================
module rst_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst1,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b1};
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// reset_sequencer: hold all domains in reset, then release them one by one.
// Optional RESET_SEQ_SW_REQ_EN adds a software re-sequence request. Rev 1.0
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STAGGER     = DEF_STAGGER,
    parameter int NUM_OUT     = DEF_NUM_OUT
) (
    input  logic               clk,
    input  logic               rst1,
    input  logic               sw_rst_req,
    output logic               sw_rst_ack,
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               done
);

    localparam int CNT_W = $clog2(max(HOLD_CYCLES, STAGGER) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);

    reset_seq_state_e   state;
    logic [CNT_W-1:0]   cnt;
    logic               sync_out;
    logic [NUM_OUT-1:0] rel_next;
    logic               step_now;

    rst_sync_chain #(
        .STAGES   (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst1     (rst1),
        .sync_out (sync_out)
    );

    // Releasing is a shift-in of ones, so the mask itself tracks progress.
    assign rel_next = (rst_n_out << 1) | NUM_OUT'(1);

    always_comb begin
        step_now = 1'b0;
        if (state == HOLD) begin
            step_now = (cnt == HOLD_LAST);
        end else if (state == RELEASE) begin
            step_now = (cnt == STAGGER_LAST);
        end
    end

`ifdef RESET_SEQ_SW_REQ_EN
    logic ack_q;
    logic sw_origin;

    assign sw_rst_ack = ack_q;
`else
    logic unused_sw_req;

    assign unused_sw_req = sw_rst_req;
    assign sw_rst_ack    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            state     <= RESET;
            cnt       <= '0;
            rst_n_out <= '0;
            done      <= 1'b0;
`ifdef RESET_SEQ_SW_REQ_EN
            ack_q     <= 1'b0;
            sw_origin <= 1'b0;
`endif
        end else begin
`ifdef RESET_SEQ_SW_REQ_EN
            ack_q <= 1'b0;
`endif
            unique case (state)
                RESET: begin
                    if (sync_out) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD, RELEASE: begin
                    if (step_now) begin
                        cnt       <= '0;
                        rst_n_out <= rel_next;
                        if (rel_next[NUM_OUT-1]) begin
                            state <= RUN;
                            done  <= 1'b1;
`ifdef RESET_SEQ_SW_REQ_EN
                            ack_q     <= sw_origin;
                            sw_origin <= 1'b0;
`endif
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
`ifdef RESET_SEQ_SW_REQ_EN
                    if (sw_rst_req) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        rst_n_out <= '0;
                        done      <= 1'b0;
                        sw_origin <= 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// tb_reset_sequencer: edge-count model of release times plus directed checks.
// Rev 1.0
// ============================================================================
module tb_reset_sequencer;

    localparam int S  = 2;
    localparam int H  = 16;
    localparam int ST = 4;
    localparam int N  = 4;
`ifdef RESET_SEQ_SW_REQ_EN
    localparam bit SW_EN = 1'b1;
`else
    localparam bit SW_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst1;
    logic         sw_rst_req;
    logic         sw_rst_ack;
    logic [N-1:0] rst_n_out;
    logic         done;
    logic         sw_rst_ack2;
    logic [0:0]   rst_n_out2;
    logic         done2;

    int checks   = 0;
    int failures = 0;

    // Model: edges since rst1 release, and the edge a sequence is timed from.
    int e      = 0;
    int base   = S + 1;
    bit sw_org = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk        (clk),
        .rst1       (rst1),
        .sw_rst_req (sw_rst_req),
        .sw_rst_ack (sw_rst_ack),
        .rst_n_out  (rst_n_out),
        .done       (done)
    );

    reset_sequencer #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (1),
        .STAGGER     (1),
        .NUM_OUT     (1)
    ) dut_min (
        .clk        (clk),
        .rst1       (rst1),
        .sw_rst_req (1'b0),
        .sw_rst_ack (sw_rst_ack2),
        .rst_n_out  (rst_n_out2),
        .done       (done2)
    );

    always @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            e      = 0;
            base   = S + 1;
            sw_org = 1'b0;
        end else begin
            bit was_run;
            was_run = (e >= base + H + (N - 1) * ST);
            e = e + 1;
            if (SW_EN && was_run && sw_rst_req) begin
                base   = e;
                sw_org = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_bits;
        logic         exp_done;
        logic         exp_ack;
        for (int i = 0; i < N; i++) exp_bits[i] = (e >= base + H + i * ST);
        exp_done = (e >= base + H + (N - 1) * ST);
        exp_ack  = sw_org && (e == base + H + (N - 1) * ST);
        checks++;
        if (rst_n_out !== exp_bits || done !== exp_done || sw_rst_ack !== exp_ack) begin
            failures++;
            $display("FAIL model_cmp edge=%0d rst_n_out=%b done=%b ack=%b required rst_n_out=%b done=%b ack=%b",
                     e, rst_n_out, done, sw_rst_ack, exp_bits, exp_done, exp_ack);
        end
        checks++;
        if (rst_n_out2 !== 1'(e >= 4) || done2 !== (e >= 4) || sw_rst_ack2 !== 1'b0) begin
            failures++;
            $display("FAIL model_cmp_min edge=%0d rst_n_out=%b done=%b ack=%b required %b %b 0",
                     e, rst_n_out2, done2, sw_rst_ack2, (e >= 4), (e >= 4));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic goto_edge(input int target);
        for (int k = 0; k < 2000 && e < target; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (e != target) begin
            failures++;
            $display("FAIL goto_edge actual=%0d required=%0d", e, target);
        end
    endtask

    task automatic pulse_rst();
        rst1 = 1'b0;
        #1;
        check("async_rst_out", 32'(rst_n_out), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        check("async_rst_min", 32'(rst_n_out2), 32'h0);
        #1;
        rst1 = 1'b1;
    endtask

    initial begin
        rst1       = 1'b0;
        sw_rst_req = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_out", 32'(rst_n_out), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_ack", 32'(sw_rst_ack), 32'h0);

        @(negedge clk);
        rst1 = 1'b1;
        goto_edge(3);
        check("min_e3", 32'(rst_n_out2), 32'h0);
        goto_edge(4);
        check("min_e4_out", 32'(rst_n_out2), 32'h1);
        check("min_e4_done", 32'(done2), 32'h1);
        goto_edge(18);
        check("pwr_e18", 32'(rst_n_out), 32'h0);
        goto_edge(19);
        check("pwr_e19", 32'(rst_n_out), 32'h1);
        goto_edge(23);
        check("pwr_e23", 32'(rst_n_out), 32'h3);
        goto_edge(25);
        pulse_rst();

        // Restarted run, with a request held through RELEASE that must be ignored.
        goto_edge(18);
        check("rst2_e18", 32'(rst_n_out), 32'h0);
        goto_edge(19);
        check("rst2_e19", 32'(rst_n_out), 32'h1);
        @(negedge clk);
        sw_rst_req = 1'b1;
        goto_edge(23);
        check("rst2_e23", 32'(rst_n_out), 32'h3);
        goto_edge(27);
        check("rst2_e27", 32'(rst_n_out), 32'h7);
        check("rst2_e27_done", 32'(done), 32'h0);
        goto_edge(30);
        @(negedge clk);
        sw_rst_req = 1'b0;
        goto_edge(31);
        check("rst2_e31", 32'(rst_n_out), 32'hf);
        check("rst2_e31_done", 32'(done), 32'h1);
        goto_edge(32);
        check("rst2_no_ack", 32'(sw_rst_ack), 32'h0);

        goto_edge(40);
        @(negedge clk);
        sw_rst_req = 1'b1;
`ifdef RESET_SEQ_SW_REQ_EN
        goto_edge(41);
        check("sw_e41_out", 32'(rst_n_out), 32'h0);
        check("sw_e41_done", 32'(done), 32'h0);
        @(negedge clk);
        sw_rst_req = 1'b0;
        goto_edge(56);
        check("sw_e56", 32'(rst_n_out), 32'h0);
        goto_edge(57);
        check("sw_e57", 32'(rst_n_out), 32'h1);
        goto_edge(68);
        check("sw_e68_ack", 32'(sw_rst_ack), 32'h0);
        goto_edge(69);
        check("sw_e69_out", 32'(rst_n_out), 32'hf);
        check("sw_e69_ack", 32'(sw_rst_ack), 32'h1);
        goto_edge(70);
        check("sw_e70_ack", 32'(sw_rst_ack), 32'h0);
`else
        goto_edge(50);
        check("nosw_out", 32'(rst_n_out), 32'hf);
        check("nosw_done", 32'(done), 32'h1);
        check("nosw_ack", 32'(sw_rst_ack), 32'h0);
        @(negedge clk);
        sw_rst_req = 1'b0;
`endif
        repeat (4) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Reset generation stage feeding the register banks of the datapath. Takes the raw asynchronous active-low reset, synchronizes its deassertion to `clk`, holds all domains in reset for a programmable interval, then releases per-domain active-low resets one at a time in a fixed staggered order. Each output is driven from exactly one register, so downstream flops see one clean asynchronous-assert, synchronous-deassert reset each. An optional software reset request re-runs the hold/release sequence without toggling `rst1`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth, ≥2.
- `HOLD_CYCLES`, default 16: cycles all outputs stay asserted after sync release, ≥1.
- `STAGGER`, default 4: cycles between consecutive domain releases, ≥1.
- `NUM_OUT`, default 4: number of reset domains, ≥1.

Ports:
- `clk` input 1: clock.
- `rst1` input 1: reset, asynchronous, active-low.
- `sw_rst_req` input 1: software reset request, sampled on `clk`.
- `sw_rst_ack` output 1: one-cycle pulse when a software-initiated sequence completes.
- `rst_n_out` output NUM_OUT: per-domain active-low resets.
- `done` output 1: high while in RUN (all domains released).

## Operation
- States: RESET, HOLD, RELEASE, RUN.
- `rst1` low: asynchronously force state RESET, synchronizer chain 0, counters 0, `rst_n_out`=0, `done`=0, `sw_rst_ack`=0. Applies at any time, including mid-sequence.
- RESET → HOLD on the first edge at which the synchronizer output is 1.
- HOLD: counter counts HOLD_CYCLES cycles, then → RELEASE with `rst_n_out[0]` set to 1 on the same edge.
- RELEASE: every STAGGER cycles set the next bit, index order 0..NUM_OUT-1. Release never reverts. The edge that sets bit NUM_OUT-1 enters RUN and sets `done`=1. If NUM_OUT=1, HOLD goes directly to RUN.
- RUN with `sw_rst_req`=1 at an edge: on that edge `rst_n_out`=0, `done`=0, state HOLD, and a "software origin" flag is set. The sequence then proceeds as above.
- On RUN entry with the flag set, pulse `sw_rst_ack` for that one cycle and clear the flag.
- `sw_rst_req` in RESET, HOLD or RELEASE: ignored. It is not latched and not acknowledged.
- Counter width: `$clog2(max(HOLD_CYCLES,STAGGER)+1)`. It reloads to 0 on every state or domain step. No wrap occurs inside a step.

## Timing
- E1 is the first rising edge with `rst1` high. The synchronizer output goes high at E(S), where S=SYNC_STAGES, and HOLD is entered at E(S+1).
- `rst_n_out[i]` deasserts at E(S+1+HOLD_CYCLES+i·STAGGER).
- `done` rises with the last bit.
- Defaults: bit0 at E19, bit1 at E23, bit2 at E27, bit3 at E31, `done` at E31.
- Software request accepted at edge E: outputs are 0 after E, bit i deasserts at E+HOLD_CYCLES+i·STAGGER, and `sw_rst_ack` is high for exactly the cycle following E+HOLD_CYCLES+(NUM_OUT-1)·STAGGER.
- Reset assertion has zero-clock latency, because it is asynchronous. Deassertion is always registered.

## Configuration
- `RESET_SEQ_SW_REQ_EN` defined: software request path and origin flag present, as described above.
- Not defined: `sw_rst_req` is unused, `sw_rst_ack` is tied 0, and the RUN state has no exit except `rst1`.

## Structure
- Package `reset_seq_pkg`:
  - state enum `reset_seq_state_e` (RESET, HOLD, RELEASE, RUN);
  - default parameter constants;
  - a `max` helper function for counter sizing.
- Sub-module `rst_sync_chain`: SYNC_STAGES-deep flop chain. Asynchronously cleared by `rst1`, input tied 1. It is instantiated once.
- FSM, counter and output registers live in `reset_sequencer`.

## Test plan
- Power-up, defaults: `rst1` low for 5 cycles then high → `rst_n_out`=0000 until E19, then 0001@E19, 0011@E23, 0111@E27, 1111@E31; `done`=1 from E31; `sw_rst_ack` never pulses.
- `rst1` pulsed low between E25 and E26 → `rst_n_out`=0000 and `done`=0 immediately, with no clock edge needed; full sequence restarts with the same offsets from the new E1.
- Macro defined, `sw_rst_req`=1 for one cycle at edge E in RUN → 0000 after E, 0001@E+16, 1111@E+28; `sw_rst_ack` high only in the cycle after E+28.
- Macro defined, `sw_rst_req` held high from E20 through E30 during RELEASE → release times unchanged (E23, E27, E31); no ack.
- Macro undefined, `sw_rst_req` held 1 in RUN → outputs stay 1111, `done`=1, `sw_rst_ack`=0.
- NUM_OUT=1, HOLD_CYCLES=1, STAGGER=1, SYNC_STAGES=2 → `rst_n_out[0]` and `done` rise at E4.
